// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl timer: FSM state width and encodings.
// 2'b11 is deliberately left unencoded; the controller treats it as IDLE.
package counter_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler: divides clk into one-cycle ticks every PRESCALE enabled cycles.
// The counter freezes while en is low and returns to zero on clr.
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable timer controller: IDLE/RUN/PAUSED FSM sequencing an up-counter
// driven by a prescaled tick, with one-shot or auto-reload terminal handling.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               mode_auto,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   term_val,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick_en;
    logic             tick_clr;

    // Ticks only advance in RUN and are suppressed by a same-cycle stop/clear;
    // outside RUN/PAUSED the prescaler is held at zero so every start is fresh.
    assign tick_en  = (state_q == ST_RUN) && !stop && !clear;
    assign tick_clr = clear || ((state_q != ST_RUN) && (state_q != ST_PAUSED));

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        term_d  = term_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        load_d  = load_val;
                        term_d  = term_val;
                        mode_d  = mode_auto;
                        count_d = load_val;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (count_q == term_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                count_d = load_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            load_q  <= '0;
            term_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl (WIDTH=4, PRESCALE=2): directed scenarios
// plus randomized traffic, compared against a cycle-level behavioural model.
module tb_counter_ctrl;

    localparam int W  = 4;
    localparam int PS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         clear = 1'b0;
    logic         mode_auto = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] term_val = '0;
    logic [W-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: 0=IDLE, 1=RUN, 2=PAUSED; phase counts cycles within a tick period.
    int   m_st, m_cnt, m_phase, m_load, m_term, m_mode, m_done;
    logic exp_tick, act_tick;

    counter_ctrl #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .mode_auto(mode_auto), .load_val(load_val), .term_val(term_val),
        .count(count), .tick(tick), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_phase = 0; m_load = 0; m_term = 0; m_mode = 0; m_done = 0;
        exp_tick = 1'b0;
    endtask

    // Advances the model by one clock edge with the given inputs.
    task automatic model_edge(input logic s, input logic p, input logic c,
                              input int lv, input int tv, input logic ma);
        exp_tick = (m_st == 1) && !p && !c && (m_phase == PS - 1);
        m_done = 0;
        if (c) begin
            m_st = 0; m_cnt = 0; m_phase = 0;
        end else if (m_st == 0) begin
            if (s) begin
                m_load = lv; m_term = tv; m_mode = int'(ma);
                m_cnt = lv; m_phase = 0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (p) begin
                m_st = 2;
            end else if (exp_tick) begin
                m_phase = 0;
                if (m_cnt == m_term) begin
                    m_done = 1;
                    if (m_mode == 1) m_cnt = m_load;
                    else m_st = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << W);
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else begin
            if (s && !p) m_st = 1;
        end
    endtask

    // Drives one cycle of inputs (entered at posedge+1, leaves at next posedge+1).
    task automatic cycle(input logic s, input logic p, input logic c,
                         input logic [W-1:0] lv, input logic [W-1:0] tv, input logic ma);
        start = s; stop = p; clear = c; load_val = lv; term_val = tv; mode_auto = ma;
        #1;
        act_tick = tick;
        model_edge(s, p, c, int'(lv), int'(tv), ma);
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, load_val, term_val, mode_auto);
    endtask

    function automatic logic [8:0] exp_vec();
        logic [W-1:0] c;
        logic [1:0]   s;
        c = m_cnt[W-1:0];
        s = m_st[1:0];
        return {c, s, (m_st != 0), (m_done != 0), exp_tick};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {count, state, busy, done, act_tick};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({count, state, busy, done, tick} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got cnt=%0d st=%0d busy=%b done=%b tick=%b expected all zero",
                     count, state, busy, done, tick);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got %b expected %b (cnt,st,busy,done,tick)", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] plan_cnt[8]  = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        logic         plan_done[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         plan_busy[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cycle(1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle_cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL one_shot_model edge %0d got %b expected %b", i, obs_vec(), exp_vec());
            end
            vectors++;
            if ({count, done, busy} !== {plan_cnt[i], plan_done[i], plan_busy[i]}) begin
                miscompares++;
                $display("FAIL one_shot_plan edge %0d got cnt=%0d done=%b busy=%b expected cnt=%0d done=%b busy=%b",
                         i, count, done, busy, plan_cnt[i], plan_done[i], plan_busy[i]);
            end
        end
    endtask

    task automatic test_auto_reload();
        int dones = 0;
        int busy_low = 0;
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            idle_cycle();
            if (done) dones++;
            if (!busy) busy_low++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_reload_model edge %0d got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (dones !== 2 || busy_low !== 0) begin
            miscompares++;
            $display("FAIL auto_reload_pulses got dones=%0d busy_low=%0d expected dones=2 busy_low=0",
                     dones, busy_low);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_pause_resume();
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0);
        idle_cycle();
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0);
        vectors++;
        if ({state, count, act_tick} !== {2'b10, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL pause_enter got st=%0d cnt=%0d tick=%b expected st=2 cnt=0 tick=0",
                     state, count, act_tick);
        end
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            vectors++;
            if (obs_vec() !== exp_vec() || count !== 4'd0 || act_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL pause_hold cycle %0d got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0);
        idle_cycle();
        vectors++;
        if ({act_tick, count, state} !== {1'b1, 4'd1, 2'b01}) begin
            miscompares++;
            $display("FAIL resume_tick got tick=%b cnt=%0d st=%0d expected tick=1 cnt=1 st=1",
                     act_tick, count, state);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [W-1:0] plan_cnt[10] = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        cycle(1'b1, 1'b0, 1'b0, 4'd14, 4'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) idle_cycle();
            vectors++;
            if (obs_vec() !== exp_vec() || count !== plan_cnt[i] || done !== (i == 8)) begin
                miscompares++;
                $display("FAIL wrap edge %0d got %b (cnt=%0d) expected %b (cnt=%0d)",
                         i, obs_vec(), count, exp_vec(), plan_cnt[i]);
            end
        end
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL wrap_idle got st=%0d expected st=0", state);
        end
    endtask

    task automatic test_priority();
        int dones = 0;
        cycle(1'b1, 1'b0, 1'b0, 4'd5, 4'd9, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 4'd5, 4'd9, 1'b0);
        if (done) dones++;
        idle_cycle();
        if (done) dones++;
        vectors++;
        if ({state, count, busy} !== {2'b00, 4'd0, 1'b0} || dones !== 0) begin
            miscompares++;
            $display("FAIL clear_beats_start got st=%0d cnt=%0d busy=%b dones=%0d expected 0 0 0 0",
                     state, count, busy, dones);
        end
        cycle(1'b1, 1'b0, 1'b0, 4'd5, 4'd9, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 4'd9, 1'b0);
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL stop_beats_start got st=%0d expected st=2", state);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd9, 4'd12, 1'b0);
        vectors++;
        if ({state, count} !== {2'b01, 4'd9} || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle_start_stop got st=%0d cnt=%0d expected st=1 cnt=9", state, count);
        end
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 1'b1);
        for (int i = 0; i < 3; i++) idle_cycle();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({count, state, busy, done, tick} !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset got cnt=%0d st=%0d busy=%b done=%b tick=%b expected all zero",
                     count, state, busy, done, tick);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 1'b0);
        vectors++;
        if ({state, count} !== {2'b01, 4'd2}) begin
            miscompares++;
            $display("FAIL restart_after_reset got st=%0d cnt=%0d expected st=1 cnt=2", state, count);
        end
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart_run edge %0d got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic s, p, c, ma;
        logic [W-1:0] lv, tv;
        for (int i = 0; i < 800; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 11) == 0);
            c  = ($urandom_range(0, 39) == 0);
            ma = 1'(($urandom_range(0, 1)));
            lv = 4'($urandom_range(0, 15));
            tv = 4'($urandom_range(0, 15));
            cycle(s, p, c, lv, tv, ma);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d got %b expected %b (cnt,st,busy,done,tick)",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_resume();
        test_wrap();
        test_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Programmable timer controller that sequences an up-counter datapath for the Zybo labs. A prescaler divides clk into count ticks. A 3-state FSM handles start, pause/resume, clear, one-shot vs auto-reload, and terminal-count detection. It drives count to LEDs/7-seg and issues a done pulse for downstream logic or interrupts.

Parameters:
WIDTH, 4, counter width in bits
PRESCALE, 100000, clk cycles per count tick (>=1); benches use 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin (IDLE) or resume (PAUSED)
stop  in  1  1-cycle pulse: pause when RUN
clear  in  1  1-cycle pulse: abort to IDLE, zero counter
mode_auto  in  1  1 = auto-reload at terminal, 0 = one-shot; sampled at start from IDLE
load_val  in  WIDTH  initial count; captured at start from IDLE
term_val  in  WIDTH  terminal count; captured at start from IDLE
count  out  WIDTH  current count
tick  out  1  high in the cycle a count update occurs
busy  out  1  high in RUN or PAUSED
done  out  1  registered 1-cycle pulse after terminal event
state  out  2  FSM state (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset (async, immediate, also mid-operation): state=IDLE, count=0, prescaler=0, load_r/term_r/mode_r=0, done=0. Derived outputs: tick=0, busy=0.
- Encoding: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10. 2'b11 is illegal and recovers to IDLE.
- Input priority per cycle: clear > stop > start.
- IDLE:
  - start: load_r<=load_val, term_r<=term_val, mode_r<=mode_auto, count<=load_val, prescaler<=0, go RUN.
  - stop: ignored. start+stop together in IDLE: start acts.
- RUN:
  - prescaler increments each cycle.
  - When prescaler==PRESCALE-1 and no stop/clear that cycle: tick=1 (combinational) and prescaler<=0.
    - If count==term_r (terminal): mode_r=1 -> count<=load_r, stay RUN; mode_r=0 -> count holds, go IDLE. done<=1 either way.
    - Otherwise: count<=count+1, modulo 2^WIDTH. If load_r>term_r the count wraps through 0.
  - stop: go PAUSED. Prescaler and count freeze; tick suppressed even if the prescaler is at terminal.
  - start in RUN: ignored.
- PAUSED:
  - start: go RUN, prescaler resumes from its frozen value, no reload.
  - stop, or start+stop together: remain PAUSED.
- clear (any state): go IDLE, count<=0, prescaler<=0. No done, no tick.
- Latency:
  - start edge -> count=load_val on the same edge.
  - First tick PRESCALE cycles later.
  - done asserted the cycle after the terminal tick edge, exactly one cycle wide.
- Equal values: load_val==term_val gives done after PRESCALE cycles.
- PRESCALE=1: tick every RUN cycle.
- busy = (state!=IDLE). In one-shot, busy falls on the same edge that raises done.

Decomposition:
- Package/header counter_ctrl_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSED) and the state width constant.
- Sub-module tick_gen (parameter PRESCALE):
  - Inputs: clk, rst_n, en, clr.
  - Output: tick at prescaler terminal while en.
  - Counter frozen while !en.

Test Plan (WIDTH=4, PRESCALE=2):
1. One-shot: load=1, term=3, mode=0, start at edge E0 -> count=1 (E0), 2 (E2), 3 (E4); E6 state=IDLE, count stays 3; done=1 only during the E6-E7 cycle; busy=0 from E6.
2. Auto-reload: load=0, term=2, mode=1, start -> count 0,1,2,0,1,2 changing every 2 cycles; done pulses every 6 cycles; busy stays 1.
3. Pause/resume: one-shot load=0, term=5; stop when prescaler=1 -> state=PAUSED, tick=0, count frozen for 10 cycles; start -> tick 1 cycle later, count+1.
4. Wrap: load=14, term=1, one-shot -> count 14,15,0,1, then done and IDLE.
5. Priority:
   - clear+start in RUN -> IDLE, count=0, no done.
   - start+stop in RUN -> PAUSED.
   - start+stop in IDLE -> RUN with count=load_val.
6. Async reset: drop rst_n mid-RUN between edges -> count=0, state=IDLE, busy=0 without waiting for clk; release, then start works normally.
